// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the multi-cycle ALU.
//   Opcode encodings (3 bits), FSM state encodings (2 bits) and the
//   signed-overflow helpers used by the add/subtract datapath.
package alu_pkg;

  // Opcode encodings
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MUL  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Two's-complement overflow of a+b: operands agree in sign, sum does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Two's-complement overflow of a-b: operands differ in sign, result sign flips from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter -- iterative unsigned shift-add multiplier, one bit per cycle.
//   clk, rst    : clock, async active-high reset
//   start       : load a/b and begin WIDTH iterations
//   a, b        : operands (captured on start)
//   done        : high in the cycle whose closing edge performs the last iteration
//   prod_lo     : low WIDTH bits of the product (valid with done)
//   prod_hi_nz  : high WIDTH bits of the product are nonzero (valid with done)
// done/prod_* are taken from the next-state accumulator so the owner can
// register the final product on the same edge as the last iteration.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             prod_hi_nz
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               active_q, active_d;

  // Next-state logic: load on start, otherwise one shift-add step while active.
  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done     = 1'b0;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = {(2*WIDTH){1'b0}};
      cnt_d    = {CNT_W{1'b0}};
      active_d = 1'b1;
    end else if (active_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        active_d = 1'b0;
        done     = 1'b1;
      end else begin
        active_d = 1'b1;
        done     = 1'b0;
      end
    end else begin
      done = 1'b0;
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= {(2*WIDTH){1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      active_q <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign prod_lo    = acc_d[WIDTH-1:0];
  assign prod_hi_nz = |acc_d[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_mc.sv
// alu_mc -- multi-cycle ALU with valid/ready handshake on both sides.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : operand bundle handshake (ready only in IDLE)
//   a, b, op            : operands and opcode, captured at acceptance
//   out_valid/out_ready : result handshake; result held in DONE until taken
//   result              : registered result
//   flag_z/c/v/n        : zero, carry/borrow, overflow/MUL truncation, negative
//   busy                : FSM not in IDLE
// Single-cycle ops register their result on the accepting edge; MUL runs
// the iterative multiplier for WIDTH cycles before reaching DONE.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic             busy
);

  localparam int SHW    = $clog2(WIDTH);
  localparam bit MUL_ON = (MUL_EN != 0);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             z_q, z_d, c_q, c_d, v_q, v_d, n_q, n_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   sum_s, diff_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_c_s, alu_v_s;
  logic             is_mul_s;

  logic             mul_start_s, mul_done_s, mul_hi_nz_s;
  logic [WIDTH-1:0] mul_lo_s;

  // Single-cycle datapath; MUL falls through to ADD when the multiplier is absent.
  always_comb begin
    sum_s     = {1'b0, a} + {1'b0, b};
    diff_s    = {1'b0, a} - {1'b0, b};
    alu_res_s = sum_s[WIDTH-1:0];
    alu_c_s   = sum_s[WIDTH];
    alu_v_s   = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
    case (op)
      OP_ADD, OP_MUL: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the unsigned borrow.
        alu_res_s = diff_s[WIDTH-1:0];
        alu_c_s   = diff_s[WIDTH];
        alu_v_s   = sub_ovf(a[WIDTH-1], b[WIDTH-1], diff_s[WIDTH-1]);
      end
      OP_AND: begin alu_res_s = a & b; alu_c_s = 1'b0; alu_v_s = 1'b0; end
      OP_OR:  begin alu_res_s = a | b; alu_c_s = 1'b0; alu_v_s = 1'b0; end
      OP_XOR: begin alu_res_s = a ^ b; alu_c_s = 1'b0; alu_v_s = 1'b0; end
      OP_SLT: begin
        alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
      end
      OP_SHL: begin
        alu_res_s = a << b[SHW-1:0];
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
      end
      default: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
      end
    endcase
    is_mul_s = MUL_ON && (op == OP_MUL);
  end

  // Control FSM and result/flag load.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    z_d         = z_q;
    c_d         = c_q;
    v_d         = v_q;
    n_d         = n_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    mul_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && is_mul_s) begin
          state_d     = ST_MUL;
          busy_d      = 1'b1;
          mul_start_s = 1'b1;
        end else if (in_valid) begin
          state_d     = ST_DONE;
          busy_d      = 1'b1;
          out_valid_d = 1'b1;
          result_d    = alu_res_s;
          c_d         = alu_c_s;
          v_d         = alu_v_s;
          z_d         = (alu_res_s == {WIDTH{1'b0}});
          n_d         = alu_res_s[WIDTH-1];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done_s) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = mul_lo_s;
          c_d         = 1'b0;
          v_d         = mul_hi_nz_s;
          z_d         = (mul_lo_s == {WIDTH{1'b0}});
          n_d         = mul_lo_s[WIDTH-1];
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State, result and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= {WIDTH{1'b0}};
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      n_q         <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      z_q         <= z_d;
      c_q         <= c_d;
      v_q         <= v_d;
      n_q         <= n_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  if (MUL_ON) begin : g_mul
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk        (clk),
      .rst        (rst),
      .start      (mul_start_s),
      .a          (a),
      .b          (b),
      .done       (mul_done_s),
      .prod_lo    (mul_lo_s),
      .prod_hi_nz (mul_hi_nz_s)
    );
  end else begin : g_no_mul
    assign mul_done_s  = 1'b0;
    assign mul_lo_s    = {WIDTH{1'b0}};
    assign mul_hi_nz_s = 1'b0;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign flag_n    = n_q;
  assign busy      = busy_q;

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 16, operand/result width in bits (legal 8..64).
REQ-002 The block SHALL expose parameter MUL_EN, default 1, enables opcode MUL (0: MUL behaves as ADD).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Ports SHALL be:
 clk  in  1  rising-edge clock
 rst  in  1  async active-high reset
 in_valid  in  1  operand bundle valid
 in_ready  out  1  block can accept a bundle
 a  in  WIDTH  operand A
 b  in  WIDTH  operand B
 op  in  3  opcode
 out_valid  out  1  result valid
 out_ready  in  1  consumer accepts result
 result  out  WIDTH  registered result
 flag_z  out  1  result == 0
 flag_c  out  1  carry / no-borrow-free indicator (see REQ-009)
 flag_v  out  1  signed overflow / MUL truncation
 flag_n  out  1  result[WIDTH-1]
 busy  out  1  state != IDLE

Function
REQ-005 Opcodes SHALL be: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SLT (signed A<B -> 1 else 0), 110 SHL (A << b[clog2(WIDTH)-1:0]), 111 MUL (low WIDTH bits of unsigned A*B).
REQ-006 FSM SHALL have states IDLE, MUL, DONE; in_ready = (state==IDLE); transfer occurs when in_valid && in_ready on a rising edge.
REQ-007 Non-MUL ops SHALL go IDLE->DONE; result/flags registered at the accepting edge, out_valid high the next cycle (latency 1).
REQ-008 MUL SHALL go IDLE->MUL, iterate shift-add one bit per cycle for WIDTH cycles, then ->DONE; out_valid first high WIDTH+1 cycles after acceptance.
REQ-009 ADD: flag_c = carry-out; SUB: flag_c = borrow (A<B unsigned); flag_v = signed overflow for ADD/SUB; for AND/OR/XOR/SLT/SHL flag_c=flag_v=0; MUL: flag_c=0, flag_v = high WIDTH bits of full product nonzero.
REQ-010 flag_z and flag_n SHALL be derived from the registered result for every op.
REQ-011 In DONE, result, flags and out_valid SHALL hold stable until out_valid && out_ready; then state->IDLE and out_valid deasserts the following cycle.
REQ-012 Inputs a, b, op SHALL be captured at acceptance; changes afterwards SHALL not affect the in-flight operation.
REQ-013 in_valid while busy SHALL be ignored (no transfer, no state change).
REQ-014 SHL with shift amount 0 SHALL return A unchanged; bits shifted past MSB are discarded.

Reset
REQ-015 On rst high, asynchronously: state=IDLE, result=0, all flags=0, out_valid=0, busy=0, multiplier counter/accumulator=0; in_ready=1 once rst deasserts.
REQ-016 rst asserted during MUL or DONE SHALL abort the operation with no result emitted.

Structure
REQ-017 Opcode encodings and FSM state encodings SHALL live in shared package alu_pkg.
REQ-018 The iterative multiplier SHALL be sub-module alu_mul_iter (start, a, b -> done, prod_lo, prod_hi_nz), instantiated only when MUL_EN=1.

Verification (WIDTH=16)
REQ-019 ADD a=0xFFFF b=0x0001 -> result 0x0000, Z=1 C=1 V=0 N=0, out_valid 1 cycle after accept.
REQ-020 SUB a=0x8000 b=0x0001 -> 0x7FFF, V=1 C=0 N=0; SUB a=0x0001 b=0x0002 -> 0xFFFF, C=1 N=1.
REQ-021 SLT a=0xFFFF b=0x0001 -> 0x0001; SHL a=0x0003 b=0x000F -> 0x8000, N=1.
REQ-022 MUL a=0x0100 b=0x0100 -> 0x0000, Z=1 V=1, out_valid exactly 17 cycles after accept; MUL 0x0012*0x0034 -> 0x03A8, V=0.
REQ-023 out_ready low 5 cycles after result -> result/flags stable, in_ready=0, in_valid pulses ignored; out_ready high -> IDLE next cycle.
REQ-024 rst pulse at cycle 8 of MUL -> all outputs 0 immediately, no out_valid; next ADD 0x0002+0x0003 -> 0x0005.
